// File: rtl/bus2_arbiter.sv
// bus2_arbiter: round-robin arbiter that sequences whole-line reads/writes from two caches onto bus2
// Ports: CLK, RESET (sync, active-low); REQ/CMDn/ADDRn/WDATAn from the requesters;
// GNT/WACK/RDATA/RVALID/DONE/ERR back to them; MC_* is the bus2 master side toward memory.
module bus2_arbiter #(
  parameter int ADDR_W = 15,
  parameter int DATA_W = 16,
  parameter int LINE_BYTES = 16,
  parameter int TIMEOUT = 255
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic [1:0]        REQ,
  input  logic [1:0]        CMD0,
  input  logic [1:0]        CMD1,
  input  logic [ADDR_W-1:0] ADDR0,
  input  logic [ADDR_W-1:0] ADDR1,
  input  logic [DATA_W-1:0] WDATA0,
  input  logic [DATA_W-1:0] WDATA1,
  output logic [1:0]        GNT,
  output logic [1:0]        WACK,
  output logic [DATA_W-1:0] RDATA,
  output logic [1:0]        RVALID,
  output logic [1:0]        DONE,
  output logic [1:0]        ERR,
  output logic [1:0]        MC_CMD,
  output logic [ADDR_W-1:0] MC_ADDR,
  output logic [DATA_W-1:0] MC_WDATA,
  input  logic [DATA_W-1:0] MC_RDATA,
  input  logic              MC_RESP
);
  localparam int BEATS = LINE_BYTES * 8 / DATA_W;
  localparam int BW = $clog2(BEATS + 1);
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [BW-1:0] LAST = BW'(BEATS - 1);
  localparam logic [BW-1:0] FULL = BW'(BEATS);
  localparam logic [TW-1:0] TLAST = TW'(TIMEOUT - 1);
  localparam logic [1:0] C2_NOP = 2'd0;
  typedef enum logic [2:0] {IDLE, CMD, WR, WAIT, RD, FIN, TURN} state_t;
  state_t state, nxt;
  logic w, ptr, err_f, win, abort, cap;
  logic [1:0] cmd_l, sel, rvalid_q;
  logic [ADDR_W-1:0] addr_l;
  logic [BW-1:0] beat;
  logic [TW-1:0] tmo;
  logic [DATA_W-1:0] wdata_q, rdata_q;
  // pointer only arbitrates a tie; a lone requester wins outright
  assign win = &REQ ? ptr : REQ[1];
  assign sel = w ? 2'b10 : 2'b01;
  // cmd_l[1]=0 is NOP/RESPONSE (illegal); cmd_l[0] distinguishes write from read.
  // In RD, beat reaching FULL means the burst is complete and a dropped MC_RESP is benign.
  always_comb begin
    abort = (state == CMD && !cmd_l[1]) || (state == WAIT && !MC_RESP && tmo == TLAST) ||
            (state == RD && !MC_RESP && beat != FULL);
    cap = MC_RESP && ((state == WAIT && !cmd_l[0]) || (state == RD && beat != FULL));
  end
  always_ff @(posedge CLK)
    state <= !RESET ? IDLE : nxt;
  always_comb begin
    nxt = state;
    case (state)
      IDLE: nxt = |REQ ? CMD : IDLE;
      CMD:  nxt = !cmd_l[1] ? FIN : cmd_l[0] ? WR : WAIT;
      WR:   nxt = beat == LAST ? WAIT : WR;
      WAIT: nxt = MC_RESP ? (cmd_l[0] ? FIN : RD) : tmo == TLAST ? FIN : WAIT;
      RD:   nxt = (beat == FULL || !MC_RESP) ? FIN : RD;
      FIN:  nxt = TURN;
      default: nxt = IDLE;
    endcase
  end
  always_ff @(posedge CLK)
    if (!RESET) begin
      w <= 1'b0;
      ptr <= 1'b0;
      cmd_l <= C2_NOP;
      addr_l <= '0;
      beat <= '0;
      tmo <= '0;
      err_f <= 1'b0;
      wdata_q <= '0;
      rdata_q <= '0;
      rvalid_q <= 2'b00;
    end else begin
      if (state == IDLE && |REQ) begin
        w <= win;
        ptr <= &REQ ? ~win : ptr;
        cmd_l <= win ? CMD1 : CMD0;
        addr_l <= win ? ADDR1 : ADDR0;
      end
      beat <= (state == WR || state == RD) ? beat + 1'b1 : (state == WAIT && MC_RESP) ? BW'(1) : '0;
      tmo <= state == WAIT ? tmo + 1'b1 : '0;
      err_f <= state == IDLE ? 1'b0 : err_f | abort;
      wdata_q <= state == WR ? (w ? WDATA1 : WDATA0) : '0;
      rdata_q <= cap ? MC_RDATA : '0;
      rvalid_q <= cap ? sel : 2'b00;
    end
  always_comb begin
    GNT = (state inside {CMD, WR, WAIT, RD, FIN}) ? sel : 2'b00;
    WACK = state == WR ? sel : 2'b00;
    DONE = state == FIN ? sel : 2'b00;
    ERR = (state == FIN && err_f) ? sel : 2'b00;
    MC_CMD = (state == CMD && cmd_l[1]) ? cmd_l : C2_NOP;
    MC_ADDR = state == CMD ? addr_l : '0;
    MC_WDATA = wdata_q;
    RDATA = rdata_q;
    RVALID = rvalid_q;
  end
endmodule
